// File: rtl/mii_tx_framer_pkg.sv
// Shared state type, line constants and CRC-32 step for the MII transmit framer.
package mii_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_DATA,
      ST_PAD,
      ST_FCS,
      ST_ABORT,
      ST_IFG
   } tx_state_t;

   localparam logic [3:0]  PREAMBLE_NIBBLE           = 4'h5;
   localparam logic [3:0]  SFD_NIBBLE                = 4'hD;
   localparam logic [31:0] CRC32_POLY_REFLECTED      = 32'hEDB88320;
   localparam logic [31:0] CRC32_INIT                = 32'hFFFFFFFF;
   localparam int unsigned DEFAULT_MIN_PAYLOAD_BYTES = 60;

   // Reflected CRC-32 over one nibble, bit 0 first (MII wire order).
   function automatic logic [31:0] crc32_nibble_step(input logic [31:0] crc,
                                                     input logic [3:0]  nib);
      logic [31:0] c;
      c = crc;
      for (int unsigned i = 0; i < 4; i++) begin
         if (c[0] ^ nib[i]) c = (c >> 1) ^ CRC32_POLY_REFLECTED;
         else               c = c >> 1;
      end
      return c;
   endfunction

endpackage

// File: rtl/mii_tx_framer_if.sv
// Byte-stream handshake feeding the MII transmit framer.
interface mii_tx_framer_if;
   logic [7:0] s_data;
   logic       s_valid;
   logic       s_last;
   logic       s_ready;

   modport master (output s_data, output s_valid, output s_last, input  s_ready);
   modport slave  (input  s_data, input  s_valid, input  s_last, output s_ready);
endinterface

// File: rtl/mii_tx_framer_crc32_nibble.sv
// Registered CRC-32 accumulator fed one nibble per clock; used for the Ethernet FCS.
module crc32_nibble
   import mii_tx_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        i_clear,
   input  logic        i_enable,
   input  logic [3:0]  i_nibble,
   output logic [31:0] o_crc,
   output logic [3:0]  o_fcs_lo
);

   logic [31:0] r_crc;
   logic [31:0] w_step;

   assign w_step = crc32_nibble_step(r_crc, i_nibble);

   // First FCS nibble as it will be once the nibble on i_nibble is absorbed.
   assign o_fcs_lo = ~w_step[3:0];
   assign o_crc    = r_crc;

   always_ff @(posedge clock) begin
      if (reset || i_clear) r_crc <= CRC32_INIT;
      else if (i_enable)    r_crc <= w_step;
   end

endmodule

// File: rtl/mii_tx_framer.sv
// MII transmit framer: preamble/SFD, payload nibbles, inter-frame gap.
// Define MII_TX_FCS_EN to build in minimum-length padding and the CRC-32 FCS.
module mii_tx_framer
   import mii_tx_pkg::*;
#(
   parameter int unsigned IFG_NIBBLES       = 24,
   parameter int unsigned MIN_PAYLOAD_BYTES = DEFAULT_MIN_PAYLOAD_BYTES
) (
   input  logic            clock,
   input  logic            reset,
   mii_tx_framer_if.slave  s,
   output logic            mii_tx_enable,
   output logic            mii_tx_error,
   output logic [3:0]      mii_tx_data,
   output logic            busy,
   output logic            frame_done,
   output logic            underrun
);

   localparam int unsigned     CNT_W    = (IFG_NIBBLES > 16) ? $clog2(IFG_NIBBLES) : 4;
   localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'(IFG_NIBBLES - 1);

   tx_state_t        r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [7:0]       r_byte;
   logic             r_last;
   logic             r_hi;
   logic             r_en;
   logic             r_er;
   logic [3:0]       r_txd;
   logic             r_ready;
   logic             r_busy;
   logic             r_done;
   logic             r_underrun;

`ifdef MII_TX_FCS_EN
   localparam logic [10:0] MIN_BYTES = 11'(MIN_PAYLOAD_BYTES);

   logic [10:0] r_bytes;
   logic [10:0] w_bytes_inc;
   logic        w_crc_en;
   logic        w_crc_clear;
   logic [31:0] w_crc;
   logic [31:0] w_crc_inv;
   logic [3:0]  w_fcs_lo;

   assign w_bytes_inc = (r_bytes == 11'h7FF) ? r_bytes : r_bytes + 11'd1;
   assign w_crc_en    = (r_state == ST_DATA) || (r_state == ST_PAD);
   assign w_crc_clear = !(w_crc_en || (r_state == ST_FCS));
   assign w_crc_inv   = ~w_crc;

   // The CRC absorbs each payload nibble during the cycle it is on the wire.
   crc32_nibble u_crc (
      .clock    (clock),
      .reset    (reset),
      .i_clear  (w_crc_clear),
      .i_enable (w_crc_en),
      .i_nibble (r_txd),
      .o_crc    (w_crc),
      .o_fcs_lo (w_fcs_lo)
   );
`else
   logic [10:0] w_unused_min_bytes;
   assign w_unused_min_bytes = 11'(MIN_PAYLOAD_BYTES);
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_byte     <= '0;
         r_last     <= 1'b0;
         r_hi       <= 1'b0;
         r_en       <= 1'b0;
         r_er       <= 1'b0;
         r_txd      <= '0;
         r_ready    <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_underrun <= 1'b0;
`ifdef MII_TX_FCS_EN
         r_bytes    <= '0;
`endif
      end else begin
         r_done     <= 1'b0;
         r_underrun <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               if (s.s_valid) begin
                  r_state <= ST_PREAMBLE;
                  r_cnt   <= '0;
                  r_en    <= 1'b1;
                  r_txd   <= PREAMBLE_NIBBLE;
                  r_busy  <= 1'b1;
`ifdef MII_TX_FCS_EN
                  r_bytes <= '0;
`endif
               end
            end

            ST_PREAMBLE: begin
               r_cnt <= r_cnt + CNT_W'(1);
               if (r_cnt == CNT_W'(14)) begin
                  r_txd   <= SFD_NIBBLE;
                  r_ready <= 1'b1;
               end
            end

            ST_DATA: begin
               if (!r_hi) begin
                  r_hi    <= 1'b1;
                  r_txd   <= r_byte[7:4];
                  r_ready <= !r_last;
`ifndef MII_TX_FCS_EN
                  r_done  <= r_last;
`endif
               end else if (r_last) begin
`ifdef MII_TX_FCS_EN
                  if (r_bytes < MIN_BYTES) begin
                     r_state <= ST_PAD;
                     r_hi    <= 1'b0;
                     r_txd   <= '0;
                     r_bytes <= w_bytes_inc;
                  end else begin
                     r_state <= ST_FCS;
                     r_cnt   <= '0;
                     r_txd   <= w_fcs_lo;
                  end
`else
                  r_state <= ST_IFG;
                  r_cnt   <= '0;
                  r_en    <= 1'b0;
                  r_txd   <= '0;
`endif
               end
            end

`ifdef MII_TX_FCS_EN
            ST_PAD: begin
               if (!r_hi) begin
                  r_hi <= 1'b1;
               end else if (r_bytes < MIN_BYTES) begin
                  r_hi    <= 1'b0;
                  r_bytes <= w_bytes_inc;
               end else begin
                  r_state <= ST_FCS;
                  r_cnt   <= '0;
                  r_txd   <= w_fcs_lo;
               end
            end

            ST_FCS: begin
               if (r_cnt == CNT_W'(7)) begin
                  r_state <= ST_IFG;
                  r_cnt   <= '0;
                  r_en    <= 1'b0;
                  r_txd   <= '0;
               end else begin
                  r_cnt  <= r_cnt + CNT_W'(1);
                  r_txd  <= w_crc_inv[{r_cnt[2:0] + 3'd1, 2'b00} +: 4];
                  r_done <= (r_cnt == CNT_W'(6));
               end
            end
`endif

            ST_ABORT: begin
               r_state    <= ST_IFG;
               r_cnt      <= '0;
               r_en       <= 1'b0;
               r_er       <= 1'b0;
               r_txd      <= '0;
               r_underrun <= 1'b1;
            end

            ST_IFG: begin
               if (r_cnt != IFG_LAST) begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end else if (s.s_valid) begin
                  // A waiting frame starts straight from the last gap nibble.
                  r_state <= ST_PREAMBLE;
                  r_cnt   <= '0;
                  r_en    <= 1'b1;
                  r_txd   <= PREAMBLE_NIBBLE;
`ifdef MII_TX_FCS_EN
                  r_bytes <= '0;
`endif
               end else begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            end

            default: begin
               r_state <= ST_IDLE;
               r_en    <= 1'b0;
               r_er    <= 1'b0;
               r_ready <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase

         // Byte boundary (SFD or high nibble of a non-last byte): take the next byte or abort.
         if (r_ready) begin
            r_ready <= 1'b0;
            if (s.s_valid) begin
               r_state <= ST_DATA;
               r_byte  <= s.s_data;
               r_last  <= s.s_last;
               r_hi    <= 1'b0;
               r_txd   <= s.s_data[3:0];
`ifdef MII_TX_FCS_EN
               r_bytes <= w_bytes_inc;
`endif
            end else begin
               r_state <= ST_ABORT;
               r_er    <= 1'b1;
               r_txd   <= '0;
            end
         end
      end
   end

   assign s.s_ready     = r_ready;
   assign mii_tx_enable = r_en;
   assign mii_tx_error  = r_er;
   assign mii_tx_data   = r_txd;
   assign busy          = r_busy;
   assign frame_done    = r_done;
   assign underrun      = r_underrun;

endmodule

// File: tb/tb_mii_tx_framer.sv
// Scoreboard bench for mii_tx_framer: expected nibbles queued at stimulus time, popped per TX_EN cycle.
module tb_mii_tx_framer;

   localparam int IFG  = 24;
   localparam int MINB = 60;

   logic       clk;
   logic       rst;
   logic       en;
   logic       er;
   logic [3:0] txd;
   logic       busy;
   logic       done;
   logic       und;

   mii_tx_framer_if sif ();

   mii_tx_framer #(
      .IFG_NIBBLES       (IFG),
      .MIN_PAYLOAD_BYTES (MINB)
   ) dut (
      .clock         (clk),
      .reset         (rst),
      .s             (sif),
      .mii_tx_enable (en),
      .mii_tx_error  (er),
      .mii_tx_data   (txd),
      .busy          (busy),
      .frame_done    (done),
      .underrun      (und)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [7:0] frame[$];
   logic [4:0] exp_q[$];
   int         len_q[$];
   bit         abt_q[$];

   int exp_dones = 0, exp_unds = 0, dones = 0, unds = 0;
   int ready_in_gap = 0;
   bit mon_on = 1'b0;
   int run = 0, low_run = 0, ifg_run = 0, last_gap = -1;
   bit seen_frame = 1'b0, prev_en = 1'b0, prev_done = 1'b0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c ^ {24'd0, b};
      for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   task automatic make_frame(input int n, input bit rnd);
      frame.delete();
      for (int i = 0; i < n; i++) frame.push_back(rnd ? 8'($urandom) : 8'(i));
   endtask

   task automatic push_expect(input bit drop);
      logic [31:0] crc;
      int          nb;
      int          len;
      crc = 32'hFFFFFFFF;
      nb  = 0;
      for (int i = 0; i < 15; i++) exp_q.push_back(5'h05);
      exp_q.push_back(5'h0D);
      for (int i = 0; i < frame.size(); i++) begin
         exp_q.push_back({1'b0, frame[i][3:0]});
         exp_q.push_back({1'b0, frame[i][7:4]});
         crc = crc_byte(crc, frame[i]);
         nb++;
      end
      if (drop) begin
         exp_q.push_back(5'h10);
         len = 16 + 2 * nb + 1;
         exp_unds++;
      end else begin
`ifdef MII_TX_FCS_EN
         while (nb < MINB) begin
            exp_q.push_back(5'h00);
            exp_q.push_back(5'h00);
            crc = crc_byte(crc, 8'h00);
            nb++;
         end
         crc = ~crc;
         for (int k = 0; k < 8; k++) exp_q.push_back({1'b0, crc[4*k +: 4]});
         len = 16 + 2 * nb + 8;
`else
         len = 16 + 2 * nb;
`endif
         exp_dones++;
      end
      len_q.push_back(len);
      abt_q.push_back(drop);
   endtask

   // Called on a negedge; a byte is taken at the posedge after a negedge that shows s_ready high.
   task automatic send_frame(input bit drop);
      int idx    = 0;
      int budget = 4000;
      bit acc;
      push_expect(drop);
      sif.s_valid = 1'b1;
      sif.s_data  = frame[0];
      sif.s_last  = (frame.size() == 1) && !drop;
      while (idx < frame.size() && budget > 0) begin
         acc = sif.s_ready;
         @(negedge clk);
         budget--;
         if (acc) begin
            idx++;
            if (idx < frame.size()) begin
               sif.s_data = frame[idx];
               sif.s_last = (idx == frame.size() - 1) && !drop;
            end else begin
               sif.s_valid = 1'b0;
               sif.s_last  = 1'b0;
            end
         end
      end
      if (idx < frame.size()) begin
         check_val("send_timeout", 32'(idx), 32'(frame.size()));
         sif.s_valid = 1'b0;
         sif.s_last  = 1'b0;
      end
   endtask

   task automatic wait_idle();
      int b = 0;
      while ((busy || exp_q.size() != 0) && b < 5000) begin
         @(negedge clk);
         b++;
      end
      if (b >= 5000) check_val("idle_timeout", 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
   endtask

   always @(negedge clk) begin
      logic [4:0] e;
      int         l;
      bit         a;
      if (!mon_on) begin
         run        = 0;
         low_run    = 0;
         ifg_run    = 0;
         seen_frame = 1'b0;
      end else begin
         if (en) begin
            if (!prev_en && seen_frame) last_gap = low_run;
            low_run = 0;
            if (exp_q.size() == 0) check_val("nibble_unexpected", 32'd1, 32'd0);
            else begin
               e = exp_q.pop_front();
               check_val("nibble", 32'({er, txd}), 32'(e));
            end
            run++;
         end else begin
            check_val("txer_idle", 32'(er), 32'd0);
            low_run++;
            if (prev_en) begin
               seen_frame = 1'b1;
               if (len_q.size() == 0) check_val("frame_unexpected", 32'd1, 32'd0);
               else begin
                  l = len_q.pop_front();
                  a = abt_q.pop_front();
                  check_val("frame_len", 32'(run), 32'(l));
                  check_val("done_on_last", 32'(prev_done), 32'(!a));
                  check_val("underrun_pulse", 32'(und), 32'(a));
               end
               run = 0;
            end
         end
         if (!en && busy) begin
            ifg_run++;
            if (sif.s_ready) ready_in_gap++;
         end else if (ifg_run > 0) begin
            check_val("ifg_len", 32'(ifg_run), 32'(IFG));
            ifg_run = 0;
         end
         if (done) dones++;
         if (und)  unds++;
      end
      prev_en   = en;
      prev_done = done;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst         = 1'b1;
      sif.s_valid = 1'b0;
      sif.s_data  = '0;
      sif.s_last  = 1'b0;
      repeat (3) @(negedge clk);
      check_val("reset_outputs", 32'({en, er, txd, sif.s_ready, busy, done, und}), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      mon_on = 1'b1;

      // 64-byte incrementing frame
      make_frame(64, 1'b0);
      send_frame(1'b0);
      wait_idle();

      // short frame: padded when FCS is built in
      make_frame(14, 1'b1);
      send_frame(1'b0);
      wait_idle();

      // two frames back-to-back
      make_frame(20, 1'b1);
      send_frame(1'b0);
      make_frame(61, 1'b1);
      send_frame(1'b0);
      wait_idle();
      check_val("b2b_gap", 32'(last_gap), 32'(IFG));

      // underrun after byte 10
      make_frame(10, 1'b1);
      send_frame(1'b1);
      wait_idle();

      // reset 40 cycles into a frame
      mon_on      = 1'b0;
      sif.s_valid = 1'b1;
      sif.s_data  = 8'h3C;
      sif.s_last  = 1'b0;
      repeat (40) @(negedge clk);
      check_val("pre_reset_active", 32'(en), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check_val("reset_mid_frame", 32'({en, er, txd, sif.s_ready, busy, done, und}), 32'd0);
      sif.s_valid = 1'b0;
      rst         = 1'b0;
      exp_q.delete();
      len_q.delete();
      abt_q.delete();
      repeat (2) @(negedge clk);
      mon_on = 1'b1;

      // restart after reset, 20-byte frame
      make_frame(20, 1'b1);
      send_frame(1'b0);
      wait_idle();

      check_val("exp_queue_empty", 32'(exp_q.size()), 32'd0);
      check_val("frames_left", 32'(len_q.size()), 32'd0);
      check_val("done_count", 32'(dones), 32'(exp_dones));
      check_val("underrun_count", 32'(unds), 32'(exp_unds));
      check_val("ready_in_gap", 32'(ready_in_gap), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
